// File: rtl/aes_byte_stream_cipher_if.sv
//==============================================================================
// Module      : aes_byte_stream_cipher_if
// Description : Byte stream bus between a source/sink and the counter-mode cipher.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface aes_byte_stream_cipher_if;
   logic       valid_in;
   logic       new_message;
   logic [7:0] key;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       valid_out;
`ifdef AES_CIPHER_KEYSTREAM_EN
   logic [7:0] ks_out;

   modport master (
      output valid_in, new_message, key, data_in,
      input  data_out, valid_out, ks_out
   );

   modport slave (
      input  valid_in, new_message, key, data_in,
      output data_out, valid_out, ks_out
   );
`else
   modport master (
      output valid_in, new_message, key, data_in,
      input  data_out, valid_out
   );

   modport slave (
      input  valid_in, new_message, key, data_in,
      output data_out, valid_out
   );
`endif
endinterface

`default_nettype wire

// File: rtl/aes_byte_stream_cipher.sv
//==============================================================================
// Module      : aes_byte_stream_cipher
// Description : Byte-serial CTR stream cipher, keystream = AES SBOX(key ^ ctr).
//               Define AES_CIPHER_KEYSTREAM_EN to add the registered ks_out port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_byte_stream_cipher (
   input  logic                      clk,
   input  logic                      reset_n,
   aes_byte_stream_cipher_if.slave   bus
);

   localparam logic [7:0] c_sbox [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   logic [7:0] r_key;
   logic [7:0] r_ctr;
   logic [7:0] r_data_out;
   logic       r_valid_out;

   logic [7:0] w_key_eff;
   logic [7:0] w_ctr_eff;
   logic [7:0] w_ks;

   // A byte arriving with new_message already belongs to the new message.
   assign w_key_eff = bus.new_message ? bus.key : r_key;
   assign w_ctr_eff = bus.new_message ? 8'h00   : r_ctr;
   assign w_ks      = c_sbox[w_key_eff ^ w_ctr_eff];

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_key       <= 8'h00;
         r_ctr       <= 8'h00;
         r_data_out  <= 8'h00;
         r_valid_out <= 1'b0;
      end else begin
         if (bus.new_message) begin
            r_key <= bus.key;
         end
         r_valid_out <= bus.valid_in;
         if (bus.valid_in) begin
            r_data_out <= bus.data_in ^ w_ks;
            r_ctr      <= w_ctr_eff + 8'h01;
         end else begin
            r_ctr      <= w_ctr_eff;
         end
      end
   end

   assign bus.data_out  = r_data_out;
   assign bus.valid_out = r_valid_out;

`ifdef AES_CIPHER_KEYSTREAM_EN
   logic [7:0] r_ks_out;

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_ks_out <= 8'h00;
      end else if (bus.valid_in) begin
         r_ks_out <= w_ks;
      end
   end

   assign bus.ks_out = r_ks_out;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_byte_stream_cipher.sv
//==============================================================================
// Module      : tb_aes_byte_stream_cipher
// Description : Directed self-checking bench for aes_byte_stream_cipher.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_aes_byte_stream_cipher;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   aes_byte_stream_cipher_if bus ();

   aes_byte_stream_cipher dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs, let one rising edge pass, settle 1 time unit past it.
   task automatic drive(input logic nm, input logic [7:0] k, input logic v, input logic [7:0] d);
      bus.new_message = nm;
      bus.key         = k;
      bus.valid_in    = v;
      bus.data_in     = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 8'h00, i[0] ? 1'b0 : 1'b1, 8'hA5 + 8'(i));
         checks++;
         if (bus.data_out !== 8'h00 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold%0d: data_out=%h valid_out=%b expected 00/0", i, bus.data_out, bus.valid_out);
         end
      end
      reset_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      checks++;
      if (bus.data_out !== 8'h00 || bus.valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: data_out=%h valid_out=%b expected 00/0", bus.data_out, bus.valid_out);
      end
   endtask

   task automatic test_keystream();
      logic [7:0] exp_ks [4];
      exp_ks = '{8'h82, 8'hCA, 8'h7D, 8'hC9};
      drive(1'b1, 8'h11, 1'b0, 8'h00);
      checks++;
      if (bus.valid_out !== 1'b0) begin
         errors++;
         $display("FAIL ks_load_valid: valid_out=%b expected 0", bus.valid_out);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 8'hFF, 1'b1, 8'h00);
         checks++;
         if (bus.data_out !== exp_ks[i] || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL keystream%0d: data_out=%h valid_out=%b expected %h/1", i, bus.data_out, bus.valid_out, exp_ks[i]);
         end
`ifdef AES_CIPHER_KEYSTREAM_EN
         checks++;
         if (bus.ks_out !== exp_ks[i]) begin
            errors++;
            $display("FAIL ks_out%0d: ks_out=%h expected %h", i, bus.ks_out, exp_ks[i]);
         end
`endif
      end
   endtask

   task automatic test_round_trip();
      logic [7:0] exp_pt [2];
      logic [7:0] pt [8];
      logic [7:0] ct [8];
      exp_pt = '{8'h82, 8'hCA};
      drive(1'b1, 8'h11, 1'b0, 8'h00);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 8'h00, 1'b1, exp_pt[i]);
         checks++;
         if (bus.data_out !== 8'h00 || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL decrypt%0d: data_out=%h valid_out=%b expected 00/1", i, bus.data_out, bus.valid_out);
         end
      end
      for (int i = 0; i < 8; i++) pt[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 8; i++) begin
         drive(i == 0, 8'h5A, 1'b1, pt[i]);
         ct[i] = bus.data_out;
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         drive(i == 0, 8'h5A, 1'b1, ct[i]);
         checks++;
         if (bus.data_out !== pt[i] || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL roundtrip%0d: data_out=%h valid_out=%b expected %h/1", i, bus.data_out, bus.valid_out, pt[i]);
         end
      end
   endtask

   task automatic test_gap();
      drive(1'b1, 8'h11, 1'b0, 8'h00);
      drive(1'b0, 8'h00, 1'b1, 8'h00);
      checks++;
      if (bus.data_out !== 8'h82 || bus.valid_out !== 1'b1) begin
         errors++;
         $display("FAIL gap_byte0: data_out=%h valid_out=%b expected 82/1", bus.data_out, bus.valid_out);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 8'h00, 1'b0, 8'h3C);
         checks++;
         if (bus.data_out !== 8'h82 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle%0d: data_out=%h valid_out=%b expected 82/0", i, bus.data_out, bus.valid_out);
         end
      end
      drive(1'b0, 8'h00, 1'b1, 8'h00);
      checks++;
      if (bus.data_out !== 8'hCA || bus.valid_out !== 1'b1) begin
         errors++;
         $display("FAIL gap_byte1: data_out=%h valid_out=%b expected CA/1", bus.data_out, bus.valid_out);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 8'h00, 1'b1, 8'h00);
      checks++;
      if (bus.data_out !== 8'h63 || bus.valid_out !== 1'b1) begin
         errors++;
         $display("FAIL sameclk_first: data_out=%h valid_out=%b expected 63/1", bus.data_out, bus.valid_out);
      end
      drive(1'b0, 8'h99, 1'b1, 8'h00);
      checks++;
      if (bus.data_out !== 8'h7C || bus.valid_out !== 1'b1) begin
         errors++;
         $display("FAIL sameclk_second: data_out=%h valid_out=%b expected 7C/1", bus.data_out, bus.valid_out);
      end
   endtask

   task automatic test_wrap_and_reset();
      drive(1'b1, 8'h11, 1'b0, 8'h00);
      for (int i = 0; i < 257; i++) begin
         drive(1'b0, 8'h00, 1'b1, 8'h00);
         if (i == 255) begin
            checks++;
            if (bus.data_out !== 8'h28) begin
               errors++;
               $display("FAIL wrap_ctrFF: data_out=%h expected 28", bus.data_out);
            end
         end
         if (i == 256) begin
            checks++;
            if (bus.data_out !== 8'h82 || bus.valid_out !== 1'b1) begin
               errors++;
               $display("FAIL wrap_ctr00: data_out=%h valid_out=%b expected 82/1", bus.data_out, bus.valid_out);
            end
         end
      end
      // Assert reset between edges while a byte is presented.
      bus.valid_in = 1'b1;
      reset_n      = 1'b1;
      #1;
      checks++;
      if (bus.data_out !== 8'h00 || bus.valid_out !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: data_out=%h valid_out=%b expected 00/0", bus.data_out, bus.valid_out);
      end
      drive(1'b0, 8'h00, 1'b1, 8'h00);
      reset_n = 1'b0;
      // Without a new message, key_reg=00 and ctr=00 give SBOX(00).
      drive(1'b0, 8'h77, 1'b1, 8'h00);
      checks++;
      if (bus.data_out !== 8'h63 || bus.valid_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_cleared_state: data_out=%h valid_out=%b expected 63/1", bus.data_out, bus.valid_out);
      end
      drive(1'b1, 8'h11, 1'b1, 8'h00);
      checks++;
      if (bus.data_out !== 8'h82 || bus.valid_out !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_msg: data_out=%h valid_out=%b expected 82/1", bus.data_out, bus.valid_out);
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      reset_n         = 1'b1;
      bus.valid_in    = 1'b0;
      bus.new_message = 1'b0;
      bus.key         = 8'h00;
      bus.data_in     = 8'h00;
      @(posedge clk);
      #1;
      test_reset();
      test_keystream();
      test_round_trip();
      test_gap();
      test_back_to_back();
      test_wrap_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/aes_byte_stream_cipher.md
Name:
aes_byte_stream_cipher

Overview:
- Byte-serial stream cipher in counter mode.
- Each accepted input byte is XORed with a keystream byte, KS = SBOX(key_eff XOR ctr_eff), where SBOX is the standard AES forward S-box.
- 8-bit key, 8-bit block counter, one byte per clock, registered output with 1-cycle latency.
- Sits between a byte source and sink. The operation is symmetric: the same block both encrypts and decrypts.

Parameters:
- None. Datapath widths are fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-high reset.
- valid_in  input  1  data_in holds a byte to process this cycle.
- new_message  input  1  start of message: load key, restart counter.
- key  input  8  key byte, sampled only when new_message=1.
- data_in  input  8  plaintext/ciphertext byte.
- data_out  output  8  processed byte (registered).
- valid_out  output  1  data_out updated this cycle (registered).

Behaviour:
- Reset: clk is the clock; reset_n is asynchronous and active-high.
  - While reset_n=1, all state is cleared: key_reg=0x00, ctr=0x00, data_out=0x00, valid_out=0.
  - Normal operation resumes on the first rising clk edge after reset_n falls.
  - Reset during a message discards the key and counter state.
- Effective values, combinational each cycle:
  - key_eff = new_message ? key : key_reg
  - ctr_eff = new_message ? 0x00 : ctr
- Keystream: KS = SBOX(key_eff ^ ctr_eff), implemented as a 256-entry combinational AES S-box table.
  - Reference entries: SBOX(00)=63, SBOX(01)=7C, SBOX(10)=CA, SBOX(11)=82, SBOX(12)=C9, SBOX(13)=7D, SBOX(EE)=28.
- At each rising edge:
  - If new_message=1: key_reg <= key.
  - If valid_in=1:
    - data_out <= data_in ^ KS
    - valid_out <= 1
    - ctr <= ctr_eff + 1 (mod 256)
  - If valid_in=0:
    - valid_out <= 0
    - data_out holds its previous value
    - ctr <= ctr_eff. If new_message=1 this sets ctr to 0x00; otherwise ctr is unchanged.
- Simultaneous new_message=1 and valid_in=1: that byte is the first byte of the new message. It uses the new key and counter 0, and ctr becomes 0x01.
- Counter wrap: after the byte processed at ctr=0xFF, ctr becomes 0x00 with no flag or stall.
- Latency: exactly 1 cycle from valid_in to valid_out. Throughput is 1 byte/cycle, there is no backpressure, and gaps in valid_in are allowed.
- No X-propagation guard is required. data_in and key are don't-care when not sampled.

Optional Feature:
- Macro: AES_CIPHER_KEYSTREAM_EN.
- Defined:
  - Adds output port ks_out (8 bits).
  - ks_out is registered alongside data_out: it loads KS when valid_in=1, otherwise holds. Reset value is 0x00.
  - Used for debug and keystream checking.
- Undefined:
  - Port ks_out is absent.
  - Behaviour is otherwise identical.

Test Plan:
1. Reset: hold reset_n=1 for 2 cycles while toggling valid_in and data_in -> data_out=0x00 and valid_out=0 throughout. Deassert reset_n -> outputs remain 0x00/0.
2. Keystream: pulse new_message=1 with key=0x11 and valid_in=0, then 4 cycles of valid_in=1 with data_in=0x00 -> data_out=0x82, 0xCA, 0x7D, 0xC9 on consecutive cycles. Each appears one cycle after its input, with valid_out=1.
3. Round trip: new_message with key=0x11, then data_in=0x82, 0xCA -> data_out=0x00, 0x00. Feeding outputs of random plaintext back through a fresh message restores the plaintext.
4. Gap: key 0x11, byte0 0x00 -> 0x82. Then valid_in=0 for 2 cycles -> valid_out=0 and data_out holds 0x82. Next byte 0x00 -> 0xCA (counter not advanced during the gap).
5. Same-cycle start: while ctr is mid-message, drive new_message=1, valid_in=1, key=0x00, data_in=0x00 -> data_out=0x63. Next byte 0x00 -> 0x7C.
6. Wrap and mid-message reset:
   - Key 0x11, 256 bytes of 0x00: byte 255 -> 0x28, byte 256 -> 0x82 (counter wrapped).
   - Then assert reset_n=1 mid-stream and release. new_message with key 0x11 and byte 0x00 -> 0x82.
